// File: rtl/rgb_pwm_capture.sv
// rgb_pwm_capture
//
// Measures an asynchronous PWM waveform against the internal oscillator.
// Once per full PWM period (rising edge to rising edge) it reports how many
// clock cycles the input was high and how long the period was. It also flags
// an input that has stopped toggling (stuck high or stuck low).
//
// Ports:
//   int_osc    in   system clock (internal HF oscillator)
//   rst        in   asynchronous active-high reset
//   pwm_in     in   PWM input, asynchronous to int_osc
//   enable     in   measurement enable; low forces IDLE
//   high_cnt   out  high cycles in the last completed period
//   period_cnt out  cycles between the last two rising edges
//   meas_valid out  one-cycle strobe when high_cnt/period_cnt update
//   stuck      out  no rising edge seen for 2^CNT_W-1 cycles
//   level      out  synchronised input level captured when stuck was set
module rgb_pwm_capture #(
    parameter int CNT_W = 24
) (
    input  logic             int_osc,
    input  logic             rst,
    input  logic             pwm_in,
    input  logic             enable,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             stuck,
    output logic             level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t           state, state_nxt;
    logic             s1, pwm_s, pwm_d;
    logic             rise;
    logic [CNT_W-1:0] per_acc, per_acc_nxt;
    logic [CNT_W-1:0] hi_acc, hi_acc_nxt;
    logic [CNT_W-1:0] per_inc, hi_inc;
    logic [CNT_W-1:0] high_cnt_nxt, period_cnt_nxt;
    logic             meas_valid_nxt, stuck_nxt, level_nxt;

    // Two-flop synchroniser plus one delay flop for rising-edge detection.
    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            pwm_s <= 1'b0;
            pwm_d <= 1'b0;
        end else begin
            s1    <= pwm_in;
            pwm_s <= s1;
            pwm_d <= pwm_s;
        end
    end

    assign rise = pwm_s & ~pwm_d;

    // Saturating increments; the accumulators must never wrap.
    assign per_inc = (per_acc == CNT_MAX) ? per_acc : per_acc + CNT_ONE;
    assign hi_inc  = (hi_acc == CNT_MAX) ? hi_acc
                                         : hi_acc + {{(CNT_W-1){1'b0}}, pwm_s};

    // Next-state and next-output logic. A rise always beats a timeout in the
    // same cycle, so a period of exactly all-ones is still reported.
    always_comb begin
        state_nxt      = state;
        per_acc_nxt    = per_acc;
        hi_acc_nxt     = hi_acc;
        high_cnt_nxt   = high_cnt;
        period_cnt_nxt = period_cnt;
        meas_valid_nxt = 1'b0;
        stuck_nxt      = stuck;
        level_nxt      = level;

        if (!enable) begin
            state_nxt   = IDLE;
            per_acc_nxt = '0;
            hi_acc_nxt  = '0;
            stuck_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    per_acc_nxt = '0;
                    hi_acc_nxt  = '0;
                    stuck_nxt   = 1'b0;
                    state_nxt   = ARM;
                end
                ARM: begin
                    hi_acc_nxt = '0;
                    if (rise) begin
                        state_nxt   = MEASURE;
                        per_acc_nxt = CNT_ONE;
                        hi_acc_nxt  = CNT_ONE;
                    end else if (per_acc == CNT_MAX) begin
                        stuck_nxt   = 1'b1;
                        level_nxt   = pwm_s;
                        per_acc_nxt = '0;
                    end else begin
                        per_acc_nxt = per_inc;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_cnt_nxt = per_acc;
                        high_cnt_nxt   = hi_acc;
                        meas_valid_nxt = 1'b1;
                        stuck_nxt      = 1'b0;
                        per_acc_nxt    = CNT_ONE;
                        hi_acc_nxt     = CNT_ONE;
                    end else if (per_acc == CNT_MAX) begin
                        stuck_nxt   = 1'b1;
                        level_nxt   = pwm_s;
                        state_nxt   = ARM;
                        per_acc_nxt = '0;
                        hi_acc_nxt  = '0;
                    end else begin
                        per_acc_nxt = per_inc;
                        hi_acc_nxt  = hi_inc;
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    per_acc_nxt = '0;
                    hi_acc_nxt  = '0;
                end
            endcase
        end
    end

    // State, accumulator and result registers.
    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            per_acc    <= '0;
            hi_acc     <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
            meas_valid <= 1'b0;
            stuck      <= 1'b0;
            level      <= 1'b0;
        end else begin
            state      <= state_nxt;
            per_acc    <= per_acc_nxt;
            hi_acc     <= hi_acc_nxt;
            high_cnt   <= high_cnt_nxt;
            period_cnt <= period_cnt_nxt;
            meas_valid <= meas_valid_nxt;
            stuck      <= stuck_nxt;
            level      <= level_nxt;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_capture.sv
// tb_rgb_pwm_capture
//
// Drives directed and random PWM waveforms into rgb_pwm_capture (CNT_W = 8 so
// that timeouts are short) and compares every output on every falling clock
// edge against a reference model. The model works from the pin history: it
// remembers the pin value sampled on each rising clock edge, finds rising
// edges of that history, and derives periods, high times and timeouts from
// edge-index differences.
module tb_rgb_pwm_capture;

    localparam int CNT_W     = 8;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int MAX_EDGES = 16384;

    logic             int_osc = 1'b0;
    logic             rst     = 1'b1;
    logic             pwm_in  = 1'b0;
    logic             enable  = 1'b0;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             stuck;
    logic             level;

    rgb_pwm_capture #(.CNT_W(CNT_W)) dut (
        .int_osc    (int_osc),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .enable     (enable),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .meas_valid (meas_valid),
        .stuck      (stuck),
        .level      (level)
    );

    always #5 int_osc = ~int_osc;

    int nChecks = 0;
    int nPass   = 0;
    int nFail   = 0;

    // Reference model state: pin value sampled at each clock edge, the edge
    // index where waiting for a first rise began, and the edge index of the
    // last accepted rise. Both at -1 means the block is idle.
    bit pinAt [0:MAX_EDGES-1];
    int edgeCnt  = 3;
    int armBase  = -1;
    int lastRise = -1;
    int expHigh, expPeriod;
    bit expValid, expStuck, expLevel;
    bit mLvl, mRise;
    int mSum;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        assert (obs === expv) nPass++;
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("meas_valid", {31'b0, meas_valid}, {31'b0, expValid});
        checkVal("stuck", {31'b0, stuck}, {31'b0, expStuck});
        checkVal("level", {31'b0, level}, {31'b0, expLevel});
        checkVal("high_cnt", {{(32-CNT_W){1'b0}}, high_cnt}, expHigh);
        checkVal("period_cnt", {{(32-CNT_W){1'b0}}, period_cnt}, expPeriod);
        if (expValid)
            checkVal("high_le_period", {31'b0, (high_cnt <= period_cnt)}, 32'd1);
    endtask

    // The pin level seen by the measuring logic at edge m is the pin sampled
    // two edges earlier; a rise is a 0->1 step in that delayed history.
    always @(posedge int_osc) begin
        edgeCnt++;
        if (edgeCnt >= MAX_EDGES) begin
            $display("[TB] FAIL edge_budget observed=%0d expected<%0d", edgeCnt, MAX_EDGES);
            $fatal(1, "[TB] edge budget exhausted");
        end
        expValid = 1'b0;
        if (rst) begin
            pinAt[edgeCnt] = 1'b0;
            armBase   = -1;
            lastRise  = -1;
            expHigh   = 0;
            expPeriod = 0;
            expStuck  = 1'b0;
            expLevel  = 1'b0;
        end else begin
            pinAt[edgeCnt] = pwm_in;
            mLvl  = pinAt[edgeCnt-2];
            mRise = pinAt[edgeCnt-2] && !pinAt[edgeCnt-3];
            if (!enable) begin
                armBase  = -1;
                lastRise = -1;
                expStuck = 1'b0;
            end else if (armBase < 0 && lastRise < 0) begin
                armBase  = edgeCnt;
                expStuck = 1'b0;
            end else if (lastRise < 0) begin
                if (mRise) begin
                    lastRise = edgeCnt;
                    armBase  = -1;
                end else if (edgeCnt - armBase - 1 == CNT_MAX) begin
                    expStuck = 1'b1;
                    expLevel = mLvl;
                    armBase  = edgeCnt;
                end
            end else begin
                if (mRise) begin
                    mSum = 0;
                    for (int j = lastRise; j < edgeCnt; j++) mSum += int'(pinAt[j-2]);
                    expPeriod = edgeCnt - lastRise;
                    expHigh   = mSum;
                    expValid  = 1'b1;
                    expStuck  = 1'b0;
                    lastRise  = edgeCnt;
                end else if (edgeCnt - lastRise == CNT_MAX) begin
                    expStuck = 1'b1;
                    expLevel = mLvl;
                    armBase  = edgeCnt;
                    lastRise = -1;
                end
            end
        end
    end

    // Outputs are compared on every falling edge, away from the active edge.
    always @(negedge int_osc) checkOutput();

    // Hold the pin at a value for n cycles, changing inputs on falling edges.
    task automatic applyStimulus(input bit p, input bit e, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge int_osc);
            pwm_in = p;
            enable = e;
        end
    endtask

    task automatic pwmPeriods(input int hiLen, input int loLen, input int reps);
        for (int r = 0; r < reps; r++) begin
            applyStimulus(1'b1, 1'b1, hiLen);
            applyStimulus(1'b0, 1'b1, loLen);
        end
    endtask

    // Asynchronous reset in the middle of a cycle: outputs must clear at once.
    task automatic midReset();
        @(negedge int_osc);
        #2;
        rst = 1'b1;
        #1;
        pinAt[edgeCnt]   = 1'b0;
        pinAt[edgeCnt-1] = 1'b0;
        pinAt[edgeCnt-2] = 1'b0;
        armBase   = -1;
        lastRise  = -1;
        expValid  = 1'b0;
        expHigh   = 0;
        expPeriod = 0;
        expStuck  = 1'b0;
        expLevel  = 1'b0;
        checkOutput();
        applyStimulus(1'b0, 1'b1, 2);
        rst = 1'b0;
    endtask

    initial begin
        int hiLen, loLen;
        $display("[TB] start");
        applyStimulus(1'b0, 1'b0, 3);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 2);

        // Steady 3-high / 5-low PWM, then minimum period.
        pwmPeriods(3, 5, 6);
        pwmPeriods(1, 1, 10);
        pwmPeriods(3, 5, 3);

        // Reset in the middle of a measurement with non-zero results held.
        applyStimulus(1'b1, 1'b1, 2);
        midReset();
        pwmPeriods(2, 4, 4);

        // Stuck high after one rise, then a 4-cycle period clears it.
        applyStimulus(1'b1, 1'b1, 300);
        pwmPeriods(2, 2, 5);

        // Stuck low.
        applyStimulus(1'b0, 1'b1, 300);
        pwmPeriods(1, 3, 5);

        // Enable dropped shortly before an expected rise, then re-enabled.
        pwmPeriods(3, 5, 3);
        applyStimulus(1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 4);
        pwmPeriods(3, 5, 4);

        // Period exactly all-ones, then one cycle longer (times out).
        pwmPeriods(1, CNT_MAX - 1, 3);
        pwmPeriods(1, CNT_MAX, 2);
        pwmPeriods(CNT_MAX - 2, 2, 2);

        // Random duty cycles with occasional enable drops.
        for (int s = 0; s < 60; s++) begin
            hiLen = $urandom_range(1, 12);
            loLen = $urandom_range(1, 12);
            applyStimulus(1'b1, 1'b1, hiLen);
            if ($urandom_range(0, 15) == 0)
                applyStimulus(1'b0, 1'b0, $urandom_range(1, 4));
            applyStimulus(1'b0, 1'b1, loLen);
        end
        hiLen = $urandom_range(100, 150);
        pwmPeriods(hiLen, CNT_MAX - hiLen, 3);

        applyStimulus(1'b0, 1'b1, 4);
        @(negedge int_osc);
        #1;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
